// File: rtl/serial_add_engine.sv
// rtl/serial_add_engine.sv - bit-serial adder front end, LSB-first sum stream
// Loads two parallel operands plus carry-in, then emits one sum bit per clock.
module serial_add_engine #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             sum_bit,
    output logic             sum_valid,
    output logic             cout,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               sum_bit_q, sum_bit_d;
    logic               sum_valid_q, sum_valid_d;
    logic               cout_q, cout_d;
    logic               done_q, done_d;
    logic               maj;

    assign maj = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        sum_bit_d   = sum_bit_q;
        sum_valid_d = 1'b0;
        cout_d      = cout_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sr_d  = a_in;
                    b_sr_d  = b_in;
                    carry_d = cin;
                    cnt_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
                carry_d     = maj;
                a_sr_d      = a_sr_q >> 1;
                b_sr_d      = b_sr_q >> 1;
                sum_valid_d = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
                // Last bit: carry out of the MSB becomes the final cout.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d  = maj;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            sum_bit_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            sum_bit_q   <= sum_bit_d;
            sum_valid_q <= sum_valid_d;
            cout_q      <= cout_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign sum_bit   = sum_bit_q;
    assign sum_valid = sum_valid_q;
    assign cout      = cout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_add_engine.sv
// tb/tb_serial_add_engine.sv - self-checking bench for serial_add_engine
// Drives 4-bit and 8-bit instances; serial capture model checks a+b+cin.
module tb_serial_add_engine;

    logic        clk = 1'b0;
    logic        reset_t = 1'b1;
    logic        start_t = 1'b0;
    logic [31:0] a_t = '0;
    logic [31:0] b_t = '0;
    logic        cin_t = 1'b0;
    logic        sel8 = 1'b0;

    logic busy4, sb4, sv4, cout4, done4;
    logic busy8, sb8, sv8, cout8, done8;
    logic busy_m, sb_m, sv_m, cout_m, done_m;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_add_engine #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset_t), .start(start_t & ~sel8),
        .a_in(a_t[3:0]), .b_in(b_t[3:0]), .cin(cin_t),
        .busy(busy4), .sum_bit(sb4), .sum_valid(sv4), .cout(cout4), .done(done4)
    );

    serial_add_engine #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset_t), .start(start_t & sel8),
        .a_in(a_t[7:0]), .b_in(b_t[7:0]), .cin(cin_t),
        .busy(busy8), .sum_bit(sb8), .sum_valid(sv8), .cout(cout8), .done(done8)
    );

    assign busy_m = sel8 ? busy8 : busy4;
    assign sb_m   = sel8 ? sb8   : sb4;
    assign sv_m   = sel8 ? sv8   : sv4;
    assign cout_m = sel8 ? cout8 : cout4;
    assign done_m = sel8 ? done8 : done4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after done.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, output logic [32:0] res, output int nv,
                          output int nb, output int done_at);
        logic [31:0] cap;
        bit got;
        cap = '0;
        got = 0;
        res = '0;
        nv = 0;
        nb = 0;
        done_at = -1;
        sel8 = (w == 8);
        a_t = a;
        b_t = b;
        cin_t = ci;
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        a_t = $urandom;
        b_t = $urandom;
        cin_t = 1'($urandom_range(0, 1));
        for (int k = 0; k < w + 4 && !got; k++) begin
            if (busy_m) nb++;
            if (sv_m) begin
                cap = {sb_m, cap[31:1]};
                nv++;
            end
            if (done_m) begin
                done_at = nv;
                got = 1;
                res = 33'(cap >> (32 - w));
                res[w] = cout_m;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [32:0] res;
        logic [32:0] exp;
        logic [9:0]  pat;
        logic [3:0]  cap4;
        logic [4:0]  r2[2];
        int          nres;
        int          nv, nb, dat;
        logic        acc;

        tbl[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0};
        tbl[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1};
        tbl[2] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
        tbl[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
        tbl[4] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0};
        tbl[5] = '{4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out4", {busy4, sb4, sv4, cout4, done4}, 0);
        chk("reset_out8", {busy8, sb8, sv8, cout8, done8}, 0);
        reset_t = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(4, 32'(tbl[i].a), 32'(tbl[i].b), tbl[i].ci, res, nv, nb, dat);
            chk($sformatf("tbl%0d_sum", i), res[3:0], tbl[i].s);
            chk($sformatf("tbl%0d_cout", i), res[4], tbl[i].co);
            chk($sformatf("tbl%0d_nvalid", i), nv, 4);
            chk($sformatf("tbl%0d_busy_cycles", i), nb, 4);
            chk($sformatf("tbl%0d_done_at", i), dat, 4);
            chk($sformatf("tbl%0d_done_pulse", i), {done_m, sv_m}, 0);
        end

        // start held high; operands change after the first load.
        sel8 = 1'b0;
        a_t = 32'b0011;
        b_t = 32'b0101;
        cin_t = 1'b0;
        start_t = 1'b1;
        pat = '0;
        cap4 = '0;
        nres = 0;
        r2[0] = '0;
        r2[1] = '0;
        @(negedge clk);
        a_t = 32'b1110;
        b_t = 32'b0111;
        cin_t = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            pat = {pat[8:0], sv_m};
            if (sv_m) cap4 = {sb_m, cap4[3:1]};
            if (done_m && nres < 2) begin
                r2[nres] = {cout_m, cap4};
                nres++;
            end
            if (k == 10) start_t = 1'b0;
            @(negedge clk);
        end
        chk("held_valid_pattern", pat, 10'b0111101111);
        chk("held_nresults", nres, 2);
        chk("held_first", r2[0], 5'b01000);
        chk("held_second", r2[1], 5'b10110);
        repeat (2) @(negedge clk);

        // Reset during the second RUN cycle aborts the operation.
        a_t = 32'b0111;
        b_t = 32'b0110;
        cin_t = 1'b1;
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        @(negedge clk);
        reset_t = 1'b1;
        @(negedge clk);
        chk("abort_out", {busy4, sb4, sv4, cout4, done4}, 0);
        reset_t = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            acc = acc | sv4 | done4 | busy4;
        end
        chk("abort_quiet", acc, 0);
        run_op(4, 32'b0111, 32'b0110, 1'b1, res, nv, nb, dat);
        chk("after_abort", res[4:0], 5'b01110);
        chk("after_abort_nvalid", nv, 4);

        for (int w = 4; w <= 8; w += 4) begin
            for (int n = 0; n < 1000; n++) begin
                logic [31:0] ra, rb;
                logic rc;
                ra = $urandom & ((32'd1 << w) - 1);
                rb = $urandom & ((32'd1 << w) - 1);
                rc = 1'($urandom_range(0, 1));
                exp = 33'(ra) + 33'(rb) + 33'(rc);
                run_op(w, ra, rb, rc, res, nv, nb, dat);
                chk($sformatf("rand_w%0d_%0d a=%0h b=%0h c=%0d", w, n, ra, rb, rc), res, exp);
                if (n % 100 == 0) chk($sformatf("rand_w%0d_%0d_nvalid", w, n), nv, w);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
